mmio_memory: RTL and testbench
==============================

Name: mmio_memory

Overview:
Parametrised successor to the current word memory with fixed IO registers. It is a single-port-write / single-port-read word RAM plus a memory-mapped IO window. The IO window holds a GPIO output register, a synchronised GPIO input, a UART transmit FIFO with a valid/ready byte stream, and a UART status/control register. It sits between the core's load/store path and the peripherals, and adds byte-lane writes, configurable sizes, and buffered UART output.

Parameters:
ADDR_W, 16, byte-address width of waddr/raddr
DEPTH, 1024, RAM size in 32-bit words (power of 2; DEPTH*4 <= IO_BASE)
IO_BASE, 16'hFF00, byte base address of the IO window (16-byte aligned)
GPIO_W, 32, width of gpio_out/gpio_in (1..32)
TX_DEPTH, 4, UART TX FIFO entries (power of 2, 2..16)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
wen  in  1  write enable
ren  in  1  read enable
wstrb  in  4  byte-lane write strobes, bit i -> wdata[8i+7:8i]
waddr  in  ADDR_W  write byte address (bits [1:0] ignored)
raddr  in  ADDR_W  read byte address (bits [1:0] ignored)
wdata  in  32  write data
rdata  out  32  registered read data
gpio_out  out  GPIO_W  GPIO output register
gpio_in  in  GPIO_W  asynchronous GPIO inputs
tx_data  out  8  byte at FIFO head
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  UART transmitter accepts byte

Behaviour:
- Reset (async assert, takes effect immediately):
  - rdata=0, gpio_out=0, GPIO synchroniser flops=0.
  - FIFO empty, tx_valid=0, tx_data=0, overflow flag=0.
  - RAM contents are not reset.
- Address decode (word address = addr[ADDR_W-1:2]):
  - RAM: addr < DEPTH*4.
  - IO: IO_BASE <= addr < IO_BASE+16. Offsets:
    - 0x0 GPIO_OUT: RW.
    - 0x4 GPIO_IN: RO.
    - 0x8 UART_TX: WO; reads return 0.
    - 0xC UART_CSR.
  - Everything else is unmapped: writes ignored, reads return 0.
- Writes (wen=1 at rising edge):
  - RAM and GPIO_OUT update only the lanes with wstrb set.
  - GPIO_OUT bits above GPIO_W are dropped.
  - wen=1 with wstrb=0 is a no-op.
- Reads:
  - One-cycle latency: when ren=1 at edge N, rdata holds the data from edge N onward.
  - ren=0: rdata holds its previous value.
  - Read and write to the same RAM word in the same cycle return the old data (read-first).
  - IO reads sample register state before the edge.
- GPIO_IN: gpio_in passes through a 2-flop synchroniser. Reads return the second-stage value zero-extended to 32 bits, so an input change is visible in rdata 3 edges after it is stable.
- UART_TX push: wen=1 to offset 0x8 with wstrb[0]=1 pushes wdata[7:0]. Other lanes are ignored.
- FIFO:
  - tx_valid = !empty and tx_data = head; both are combinational from FIFO state.
  - Pop when tx_valid && tx_ready at the edge.
  - Pointers are log2(TX_DEPTH)+1 bits and wrap naturally. Count = wptr - rptr.
- Full FIFO:
  - Push plus pop in the same cycle: both occur; count unchanged; no overflow.
  - Push with no pop: byte dropped, overflow set.
- Empty FIFO:
  - A pop cannot occur.
  - A push sets tx_valid=1 the next cycle. There is no same-cycle bypass.
- UART_CSR read value:
  - bit0 empty, bit1 full, bit2 overflow (sticky).
  - bits[12:8] count.
  - All other bits 0.
- UART_CSR write: wdata[2]=1 with wstrb[0] clears overflow (W1C). If a new overflow occurs in the same cycle, set wins.
- IO writes are independent of ren.
- Reset asserted mid-transfer discards FIFO contents. tx_valid drops immediately, asynchronously.

Test Plan:
- RAM: write 32'hDEADBEEF to 0x0200 with wstrb=4'hF, then wstrb=4'b0010 with wdata=32'h0000AA00, then read 0x0200 -> rdata=32'hDEADAAEF one edge after ren. Read 0x0000 -> 0.
- Read-first and unmapped: in the same cycle write 99 and read 0x0200 (holding 5) -> rdata=5, then next read -> 99. Read 0x8000 -> 0. Write 0x8000 has no effect on any RAM word.
- GPIO: write 32'h0000_00A5 to 0xFF00 -> gpio_out=8'hA5 the next cycle. Drive gpio_in=32'h3C -> GPIO_IN read returns 32'h3C starting 3 edges later. Assert rst -> gpio_out=0 immediately.
- UART FIFO (TX_DEPTH=4, tx_ready=0): push 0x41,0x42,0x43,0x44 -> CSR=32'h0000_0402 (count 4, full). Push 0x45 -> byte dropped, CSR bit2=1. Raise tx_ready -> tx_data emits 0x41,0x42,0x43,0x44 on consecutive edges, then tx_valid=0 and CSR=32'h0000_0005.
- Full push+pop: FIFO full and tx_ready=1, push 0x55 -> count stays 4, no overflow, 0x55 emerges fifth. Write CSR 32'h4 -> overflow cleared. W1C coinciding with an overflowing push -> overflow stays 1.
- Reset mid-stream: 2 bytes queued, assert rst while tx_ready=1 -> tx_valid=0 immediately. After release CSR=32'h0000_0001 and RAM data written earlier is still readable.

Source files
------------

// File: rtl/mmio_memory.sv
// Word RAM with byte-lane writes plus a 16-byte IO window: GPIO out/in and a
// buffered UART TX byte stream with sticky overflow status.
module mmio_memory #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 1024,
  parameter logic [ADDR_W-1:0] IO_BASE  = 16'hFF00,
  parameter int                GPIO_W   = 32,
  parameter int                TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int                RAM_AW  = $clog2(DEPTH);
  localparam int                PW      = $clog2(TX_DEPTH);
  localparam logic [ADDR_W:0]   RAM_END = (ADDR_W+1)'(DEPTH * 4);

  logic [31:0]       mem      [DEPTH];
  logic [7:0]        fifo_mem [TX_DEPTH];

  logic [31:0]       rdata_q, rdata_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [PW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic              ovf_q, ovf_d;

  logic              w_ram, w_io, r_ram, r_io;
  logic [1:0]        w_off, r_off;
  logic [PW:0]       count;
  logic              empty, full, pop, push_req, push, ovf_set, ovf_clr;
  logic [31:0]       gpio_ext, gpio_merged, csr;

  assign w_ram = ({1'b0, waddr} < RAM_END);
  assign r_ram = ({1'b0, raddr} < RAM_END);
  assign w_io  = (waddr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign r_io  = (raddr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign w_off = waddr[3:2];
  assign r_off = raddr[3:2];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wptr_q - rptr_q;
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(TX_DEPTH));
  assign pop      = !empty && tx_ready;
  assign push_req = wen && w_io && (w_off == 2'd2) && wstrb[0];
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wen && w_io && (w_off == 2'd3) && wstrb[0] && wdata[2];

  assign gpio_ext = 32'(gpio_q);
  assign csr      = {19'b0, 5'(count), 5'b0, ovf_q, full, empty};

  always_comb begin
    gpio_merged = gpio_ext;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) gpio_merged[8*i +: 8] = wdata[8*i +: 8];
    end
    gpio_d = gpio_q;
    if (wen && w_io && (w_off == 2'd0)) gpio_d = gpio_merged[GPIO_W-1:0];

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    ovf_d  = ovf_set || (ovf_q && !ovf_clr);

    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = '0;
      if (r_ram) begin
        rdata_d = mem[raddr[RAM_AW+1:2]];
      end else if (r_io) begin
        case (r_off)
          2'd0:    rdata_d = gpio_ext;
          2'd1:    rdata_d = 32'(sync2_q);
          2'd3:    rdata_d = csr;
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage arrays are not reset; only the pointers define FIFO contents.
  always_ff @(posedge clk) begin
    if (wen && w_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr[RAM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (push) fifo_mem[wptr_q[PW-1:0]] <= wdata[7:0];
  end

  assign rdata    = rdata_q;
  assign gpio_out = gpio_q;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rptr_q[PW-1:0]];

endmodule

// File: tb/tb_mmio_memory.sv
// Directed plus random bench for mmio_memory against a queue/array reference model.
module tb_mmio_memory;
  logic        clk = 1'b0;
  logic        rst, wen, ren, tx_ready;
  logic [3:0]  wstrb;
  logic [15:0] waddr, raddr;
  logic [31:0] wdata, rdata, gpio_out, gpio_in;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [int];
  logic [31:0] gpio_m, rdata_m, g1, g2;
  logic [7:0]  q_m [$];
  logic        ovf_m;

  mmio_memory dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .wstrb(wstrb),
    .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] csr_m();
    int n;
    n = q_m.size();
    return {19'b0, 5'(n), 5'b0, ovf_m, (n == 4), (n == 0)};
  endfunction

  function automatic logic [31:0] ram_rd(input logic [15:0] a);
    int k;
    k = int'(a[15:2]);
    return ram_m.exists(k) ? ram_m[k] : 32'h0;
  endfunction

  task automatic cyc(input logic w_en, input logic r_en, input logic [3:0] s,
                     input logic [15:0] wa, input logic [15:0] ra,
                     input logic [31:0] wd, input logic rdy);
    logic push_req, set, clr, pop, was_full;
    wen = w_en; ren = r_en; wstrb = s; waddr = wa; raddr = ra; wdata = wd; tx_ready = rdy;
    push_req = 1'b0; set = 1'b0; clr = 1'b0;
    if (r_en) begin
      if (ra < 16'h1000)            rdata_m = ram_rd(ra);
      else if (ra[15:4] == 12'hFF0) begin
        case (ra[3:2])
          2'd0:    rdata_m = gpio_m;
          2'd1:    rdata_m = g2;
          2'd3:    rdata_m = csr_m();
          default: rdata_m = 32'h0;
        endcase
      end else                      rdata_m = 32'h0;
    end
    if (w_en) begin
      if (wa < 16'h1000) ram_m[int'(wa[15:2])] = merge(ram_rd(wa), wd, s);
      else if (wa[15:4] == 12'hFF0) begin
        if (wa[3:2] == 2'd0) gpio_m = merge(gpio_m, wd, s);
        if (wa[3:2] == 2'd2) push_req = s[0];
        if (wa[3:2] == 2'd3) clr = s[0] && wd[2];
      end
    end
    was_full = (q_m.size() == 4);
    pop = (q_m.size() > 0) && rdy;
    if (pop) void'(q_m.pop_front());
    if (push_req) begin
      if (was_full && !pop) set = 1'b1;
      else q_m.push_back(wd[7:0]);
    end
    ovf_m = set || (ovf_m && !clr);
    g2 = g1;
    g1 = gpio_in;
    @(posedge clk);
    #1;
    chk("rdata", rdata, rdata_m);
    chk("gpio_out", gpio_out, gpio_m);
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, q_m.size() != 0});
    if (q_m.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, q_m[0]});
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic rdy);
    cyc(1'b1, 1'b0, s, a, 16'h0, d, rdy);
  endtask

  task automatic rd(input logic [15:0] a, input logic rdy);
    cyc(1'b0, 1'b1, 4'h0, 16'h0, a, 32'h0, rdy);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 32'h0, rdy);
  endtask

  // Asserts reset between edges so its asynchronous effect is observable.
  task automatic do_reset();
    wen = 1'b0; ren = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    q_m.delete();
    ovf_m = 1'b0; gpio_m = '0; rdata_m = '0; g1 = '0; g2 = '0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] addrs [11];
    logic [15:0] a1, a2;
    addrs = '{16'h0000, 16'h0004, 16'h0200, 16'h0FFC, 16'h1000, 16'h8000,
              16'hFF00, 16'hFF04, 16'hFF08, 16'hFF0C, 16'hFF10};
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wstrb = '0; waddr = '0; raddr = '0;
    wdata = '0; tx_ready = 1'b0; gpio_in = '0;
    q_m.delete();
    ovf_m = 1'b0; gpio_m = '0; rdata_m = '0; g1 = '0; g2 = '0;
    #3;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset_tx_data", {24'b0, tx_data}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // RAM byte lanes
    wr(16'h0200, 32'hDEADBEEF, 4'hF, 1'b0);
    wr(16'h0200, 32'h0000AA00, 4'b0010, 1'b0);
    wr(16'h0204, 32'h12345678, 4'h0, 1'b0);
    rd(16'h0200, 1'b0);
    chk("ram_lane", rdata, 32'hDEADAAEF);
    rd(16'h0000, 1'b0);
    chk("ram_zero", rdata, 32'h0);

    // Read-first, hold, unmapped
    wr(16'h0200, 32'd5, 4'hF, 1'b0);
    cyc(1'b1, 1'b1, 4'hF, 16'h0200, 16'h0200, 32'd99, 1'b0);
    chk("read_first", rdata, 32'd5);
    rd(16'h0200, 1'b0);
    chk("read_new", rdata, 32'd99);
    idle(1'b0);
    chk("rdata_hold", rdata, 32'd99);
    rd(16'h8000, 1'b0);
    chk("unmapped_rd", rdata, 32'h0);
    wr(16'h8000, 32'hFFFFFFFF, 4'hF, 1'b0);
    wr(16'h1000, 32'hFFFFFFFF, 4'hF, 1'b0);
    rd(16'h0000, 1'b0);
    chk("unmapped_wr0", rdata, 32'h0);
    rd(16'h0200, 1'b0);
    chk("unmapped_wr200", rdata, 32'd99);

    // GPIO
    wr(16'hFF00, 32'h000000A5, 4'hF, 1'b0);
    chk("gpio_wr", gpio_out, 32'h000000A5);
    gpio_in = 32'h3C;
    rd(16'hFF04, 1'b0);
    chk("gpio_in_e1", rdata, 32'h0);
    rd(16'hFF04, 1'b0);
    chk("gpio_in_e2", rdata, 32'h0);
    rd(16'hFF04, 1'b0);
    chk("gpio_in_e3", rdata, 32'h3C);
    do_reset();

    // UART FIFO fill, overflow, drain
    for (int i = 0; i < 4; i++) wr(16'hFF08, 32'hFFFFFF41 + i, 4'h1, 1'b0);
    rd(16'hFF0C, 1'b0);
    chk("csr_full", rdata, 32'h00000402);
    wr(16'hFF08, 32'h45, 4'h1, 1'b0);
    rd(16'hFF0C, 1'b0);
    chk("csr_ovf", rdata, 32'h00000406);
    for (int i = 0; i < 4; i++) begin
      chk("tx_seq", {24'b0, tx_data}, 32'h41 + i);
      idle(1'b1);
    end
    chk("tx_drained", {31'b0, tx_valid}, 32'h0);
    rd(16'hFF0C, 1'b1);
    chk("csr_empty_ovf", rdata, 32'h00000005);

    // W1C, full push+pop
    wr(16'hFF0C, 32'h4, 4'h1, 1'b0);
    rd(16'hFF0C, 1'b0);
    chk("w1c", rdata, 32'h00000001);
    for (int i = 0; i < 4; i++) wr(16'hFF08, 32'h61 + i, 4'h1, 1'b0);
    wr(16'hFF08, 32'h55, 4'h1, 1'b1);
    rd(16'hFF0C, 1'b0);
    chk("push_pop_full", rdata, 32'h00000402);
    for (int i = 0; i < 4; i++) begin
      chk("pp_seq", {24'b0, tx_data}, (i == 3) ? 32'h55 : 32'h62 + i);
      idle(1'b1);
    end
    for (int i = 0; i < 5; i++) wr(16'hFF08, 32'h70 + i, 4'h1, 1'b0);
    wr(16'hFF0C, 32'h4, 4'h1, 1'b0);
    rd(16'hFF0C, 1'b0);
    chk("w1c_full", rdata, 32'h00000402);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Reset mid-stream
    wr(16'hFF08, 32'h81, 4'h1, 1'b0);
    wr(16'hFF08, 32'h82, 4'h1, 1'b0);
    tx_ready = 1'b1;
    do_reset();
    rd(16'hFF0C, 1'b0);
    chk("csr_after_rst", rdata, 32'h00000001);
    rd(16'h0200, 1'b0);
    chk("ram_survives", rdata, 32'd99);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n % 16 == 0) gpio_in = $urandom;
      a1 = addrs[$urandom_range(0, 10)];
      a2 = addrs[$urandom_range(0, 10)];
      cyc(1'($urandom), 1'($urandom), 4'($urandom), a1, a2, $urandom,
          ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
